// File: rtl/irq_controller.sv
// Edge-capturing interrupt controller: latches source requests, applies a mask,
// arbitrates lowest-index-first and runs a raise/ack handshake with the CPU.
module irq_controller #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] BASE_ADDR = 8'hE0
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [7:0]       i_bus_addr,
   inout  wire  [7:0]       io_bus_data,
   input  logic             i_bus_we,
   input  logic [N_SRC-1:0] i_src_raise,
   output logic [N_SRC-1:0] o_src_ack,
   output logic             o_cpu_int_raise,
   input  logic             i_cpu_int_ack
);

   localparam logic [7:0] VALID    = 8'((9'd1 << N_SRC) - 9'd1);
   localparam logic [1:0] REG_PEND = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;
   localparam logic [1:0] REG_SOFT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_id;
   logic [2:0] w_id_next;
   logic [2:0] w_win_id;
   logic       w_any;
   logic       r_ack_pulse;
   logic       w_ack_fire;

   logic [7:0] r_pending;
   logic [7:0] r_mask;
   logic [7:0] r_src_prev;
   logic [7:0] w_src;
   logic [7:0] w_edge;
   logic [7:0] w_req;
   logic [7:0] w_w1c;
   logic [7:0] w_soft;
   logic [7:0] w_ack_clr;
   logic [7:0] w_pending_next;

   logic [7:0] w_offset;
   logic [1:0] w_reg;
   logic       w_hit;
   logic       w_wr;
   logic       w_rd;
   logic [7:0] w_rd_value;
   logic [7:0] r_rd_data;
   logic       r_rd_en;

   // Bus decode: window of four registers starting at BASE_ADDR
   assign w_offset = i_bus_addr - BASE_ADDR;
   assign w_hit    = (w_offset[7:2] == 6'd0);
   assign w_reg    = w_offset[1:0];
   assign w_wr     = w_hit & i_bus_we;
   assign w_rd     = w_hit & ~i_bus_we;

   assign w_src  = 8'(i_src_raise);
   assign w_edge = w_src & ~r_src_prev;
   assign w_w1c  = (w_wr && (w_reg == REG_PEND)) ? (io_bus_data & VALID) : 8'h00;
   assign w_soft = (w_wr && (w_reg == REG_SOFT)) ? (io_bus_data & VALID) : 8'h00;

   // Sets are applied after clears so a same-cycle new event is never lost
   assign w_pending_next = ((r_pending & ~(w_w1c | w_ack_clr)) | w_edge | w_soft) & VALID;

   always_comb begin
      w_req    = r_pending & r_mask;
      w_any    = |w_req;
      w_win_id = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_req[i]) begin
            w_win_id = 3'(i);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_id_next    = r_id;
      w_ack_fire   = 1'b0;
      w_ack_clr    = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_next = ST_REQ;
               w_id_next    = w_win_id;
            end
         end
         ST_REQ: begin
            if (i_cpu_int_ack) begin
               w_state_next     = ST_GAP;
               w_ack_fire       = 1'b1;
               w_ack_clr[r_id]  = 1'b1;
            end
         end
         ST_GAP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_rd_value = 8'h00;
      case (w_reg)
         REG_PEND: w_rd_value = r_pending;
         REG_MASK: w_rd_value = r_mask;
         REG_STAT: w_rd_value = {(r_state != ST_IDLE), 4'b0000, r_id};
         REG_SOFT: w_rd_value = 8'h00;
         default:  w_rd_value = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_id        <= 3'd0;
         r_ack_pulse <= 1'b0;
         r_pending   <= 8'h00;
         r_mask      <= VALID;
         r_src_prev  <= 8'h00;
         r_rd_data   <= 8'h00;
         r_rd_en     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_id        <= w_id_next;
         r_ack_pulse <= w_ack_fire;
         r_pending   <= w_pending_next;
         r_src_prev  <= w_src;
         r_rd_en     <= w_rd;
         if (w_rd) begin
            r_rd_data <= w_rd_value;
         end
         if (w_wr && (w_reg == REG_MASK)) begin
            r_mask <= io_bus_data & VALID;
         end
      end
   end

   // r_id stays stable through GAP, so the ack pulse can be decoded from it
   assign o_src_ack       = r_ack_pulse ? (N_SRC'(1) << r_id) : '0;
   assign o_cpu_int_raise = (r_state == ST_REQ);
   assign io_bus_data     = r_rd_en ? r_rd_data : 8'bz;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register-map vector table plus
// hand-written handshake, priority, mask, conflict and reset sequences.
module tb_irq_controller;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      logic       hiz;
   } busVec_t;

   logic       clock = 1'b0;
   logic       resetN;
   logic [7:0] busAddr;
   wire  [7:0] busData;
   logic       busWe;
   logic [3:0] srcRaise;
   logic [3:0] srcAck;
   logic       cpuIntRaise;
   logic       cpuIntAck;
   logic [7:0] tbDrive;
   logic       tbDriveEn;

   int compared   = 0;
   int mismatched = 0;
   int ackPulses  = 0;
   int savedPulses;
   logic [7:0] rd;
   busVec_t vecs[17];

   always #5 clock = ~clock;

   assign busData = tbDriveEn ? tbDrive : 8'bz;

   irq_controller #(.N_SRC(4), .BASE_ADDR(8'hE0)) dut (
      .i_clk(clock),
      .i_reset_n(resetN),
      .i_bus_addr(busAddr),
      .io_bus_data(busData),
      .i_bus_we(busWe),
      .i_src_raise(srcRaise),
      .o_src_ack(srcAck),
      .o_cpu_int_raise(cpuIntRaise),
      .i_cpu_int_ack(cpuIntAck)
   );

   always @(negedge clock) begin
      if (srcAck != 4'b0000) ackPulses = ackPulses + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared = compared + 1;
      if (actual !== expected) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
      end
   endtask

   task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
      busAddr   = addr;
      tbDrive   = data;
      tbDriveEn = 1'b1;
      busWe     = 1'b1;
      tick();
      busWe     = 1'b0;
      tbDriveEn = 1'b0;
      busAddr   = 8'h00;
   endtask

   task automatic busRead(input logic [7:0] addr, output logic [7:0] value);
      busAddr = addr;
      busWe   = 1'b0;
      tick();
      value   = busData;
      busAddr = 8'h00;
      tick();
   endtask

   task automatic checkHiz(input string name);
      tbDrive   = 8'hA5;
      tbDriveEn = 1'b1;
      #1;
      checkOutput(name, busData, 8'hA5);
      tbDriveEn = 1'b0;
      #1;
   endtask

   task automatic applyStimulus(input int idx);
      logic [7:0] value;
      if (vecs[idx].we) begin
         busWrite(vecs[idx].addr, vecs[idx].data);
      end else if (vecs[idx].hiz) begin
         busAddr = vecs[idx].addr;
         tick();
         checkHiz($sformatf("vec%0d_hiz", idx));
         busAddr = 8'h00;
         tick();
      end else begin
         busRead(vecs[idx].addr, value);
         checkOutput($sformatf("vec%0d_read", idx), value, vecs[idx].data);
      end
   endtask

   task automatic cpuAck(input logic [3:0] expAck, input string name);
      cpuIntAck = 1'b1;
      tick();
      cpuIntAck = 1'b0;
      checkOutput({name, "_ack"}, 8'(srcAck), 8'(expAck));
      checkOutput({name, "_dropRaise"}, 8'(cpuIntRaise), 8'h00);
      tick();
      checkOutput({name, "_ackEnd"}, 8'(srcAck), 8'h00);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 8'hE1, 8'h0F, 1'b0};
      vecs[1]  = '{1'b0, 8'hE0, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 8'hE2, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 8'hE3, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 8'hE4, 8'h00, 1'b1};
      vecs[5]  = '{1'b0, 8'hDF, 8'h00, 1'b1};
      vecs[6]  = '{1'b1, 8'hE1, 8'hF0, 1'b0};
      vecs[7]  = '{1'b0, 8'hE1, 8'h00, 1'b0};
      vecs[8]  = '{1'b1, 8'hE3, 8'hFA, 1'b0};
      vecs[9]  = '{1'b0, 8'hE0, 8'h0A, 1'b0};
      vecs[10] = '{1'b0, 8'hE3, 8'h00, 1'b0};
      vecs[11] = '{1'b1, 8'hE0, 8'h02, 1'b0};
      vecs[12] = '{1'b0, 8'hE0, 8'h08, 1'b0};
      vecs[13] = '{1'b1, 8'hE0, 8'hFF, 1'b0};
      vecs[14] = '{1'b0, 8'hE0, 8'h00, 1'b0};
      vecs[15] = '{1'b1, 8'hE1, 8'h0F, 1'b0};
      vecs[16] = '{1'b0, 8'hE1, 8'h0F, 1'b0};

      resetN    = 1'b0;
      busAddr   = 8'h00;
      busWe     = 1'b0;
      srcRaise  = 4'b0000;
      cpuIntAck = 1'b0;
      tbDrive   = 8'h00;
      tbDriveEn = 1'b0;
      tick();
      tick();
      resetN = 1'b1;
      checkOutput("reset_raise", 8'(cpuIntRaise), 8'h00);
      checkOutput("reset_ack", 8'(srcAck), 8'h00);
      checkHiz("reset_hiz");

      for (int v = 0; v < 17; v++) begin
         applyStimulus(v);
      end
      checkOutput("table_noRaise", 8'(cpuIntRaise), 8'h00);

      // Single held source: two-cycle latency, one ack pulse, no retrigger
      ackPulses = 0;
      srcRaise  = 4'b0010;
      tick();
      checkOutput("single_raiseK", 8'(cpuIntRaise), 8'h00);
      tick();
      checkOutput("single_raiseK1", 8'(cpuIntRaise), 8'h01);
      busRead(8'hE2, rd);
      checkOutput("single_status", rd, 8'h81);
      cpuAck(4'b0010, "single");
      busRead(8'hE0, rd);
      checkOutput("single_pendCleared", rd, 8'h00);
      repeat (4) tick();
      checkOutput("single_noRetrigger", 8'(cpuIntRaise), 8'h00);
      checkOutput("single_pulseCount", 8'(ackPulses), 8'd1);
      srcRaise = 4'b0000;
      tick();

      // Priority: sources 3 and 0 together, 0 served first
      ackPulses = 0;
      srcRaise  = 4'b1001;
      tick();
      busRead(8'hE0, rd);
      checkOutput("prio_pending", rd, 8'h09);
      busRead(8'hE2, rd);
      checkOutput("prio_status0", rd, 8'h80);
      cpuAck(4'b0001, "prio0");
      checkOutput("prio_idleGap", 8'(cpuIntRaise), 8'h00);
      tick();
      checkOutput("prio_reraise", 8'(cpuIntRaise), 8'h01);
      busRead(8'hE2, rd);
      checkOutput("prio_status3", rd, 8'h83);
      cpuAck(4'b1000, "prio3");
      srcRaise = 4'b0000;
      tick();
      checkOutput("prio_pulseCount", 8'(ackPulses), 8'd2);
      busRead(8'hE0, rd);
      checkOutput("prio_pendEmpty", rd, 8'h00);

      // Mask: masked source stays pending, unmask raises one cycle later
      busWrite(8'hE1, 8'h0E);
      srcRaise = 4'b0001;
      repeat (3) tick();
      checkOutput("mask_noRaise", 8'(cpuIntRaise), 8'h00);
      busRead(8'hE0, rd);
      checkOutput("mask_pending", rd, 8'h01);
      busWrite(8'hE1, 8'h0F);
      checkOutput("mask_writeEdge", 8'(cpuIntRaise), 8'h00);
      tick();
      checkOutput("mask_unmaskRaise", 8'(cpuIntRaise), 8'h01);
      busWrite(8'hE1, 8'h00);
      checkOutput("mask_holdAfterMask", 8'(cpuIntRaise), 8'h01);
      busWrite(8'hE0, 8'h01);
      checkOutput("mask_holdAfterW1c", 8'(cpuIntRaise), 8'h01);
      cpuAck(4'b0001, "mask");
      srcRaise = 4'b0000;
      busWrite(8'hE1, 8'h0F);

      // Software trigger and same-cycle W1C vs new edge
      busWrite(8'hE3, 8'h04);
      tick();
      checkOutput("soft_raise", 8'(cpuIntRaise), 8'h01);
      busRead(8'hE2, rd);
      checkOutput("soft_status", rd, 8'h82);
      cpuAck(4'b0100, "soft");
      busWrite(8'hE1, 8'h00);
      busWrite(8'hE3, 8'h04);
      srcRaise = 4'b0100;
      busWrite(8'hE0, 8'h04);
      busRead(8'hE0, rd);
      checkOutput("conflict_pending", rd, 8'h04);
      busWrite(8'hE1, 8'h0F);
      tick();
      checkOutput("conflict_raise", 8'(cpuIntRaise), 8'h01);
      cpuAck(4'b0100, "conflict");
      srcRaise = 4'b0000;
      tick();

      // Reset in the middle of a request
      busWrite(8'hE3, 8'h01);
      tick();
      checkOutput("rst_preRaise", 8'(cpuIntRaise), 8'h01);
      savedPulses = ackPulses;
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      checkOutput("rst_raise", 8'(cpuIntRaise), 8'h00);
      checkOutput("rst_ack", 8'(srcAck), 8'h00);
      tick();
      busRead(8'hE0, rd);
      checkOutput("rst_pending", rd, 8'h00);
      busRead(8'hE1, rd);
      checkOutput("rst_mask", rd, 8'h0F);
      checkHiz("rst_hiz");
      checkOutput("rst_noPulse", 8'(ackPulses), 8'(savedPulses));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sits between the bus peripherals (timer, mouse, IR, future sources) and the processor's interrupt line. It latches edge-triggered requests from up to 8 sources into a pending register and applies a software mask. It picks the highest-priority unmasked request and runs a raise/acknowledge handshake with the CPU, returning a one-cycle acknowledge to the winning source. Pending, mask, status and software-trigger registers are memory-mapped on the shared 8-bit bus.

## Interface
- N_SRC, 4: number of interrupt sources, 1..8
- BASE_ADDR, 8'hE0: bus base address; occupies BASE_ADDR..BASE_ADDR+3
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  reset; one clock, synchronous, active-low (RESET=0 resets on next CLK edge)
- BUS_ADDR  in  8  shared bus address
- BUS_DATA  inout  8  shared bus data; high-Z unless this block is driving a read
- BUS_WE  in  1  bus write enable
- SRC_RAISE  in  N_SRC  per-source request, held high by the source until acknowledged
- SRC_ACK  out  N_SRC  per-source acknowledge, one-cycle pulse
- CPU_INT_RAISE  out  1  interrupt request to processor
- CPU_INT_ACK  in  1  processor acknowledge

## Operation
- Register map:
  - BASE+0 PENDING: read; write-1-to-clear.
  - BASE+1 MASK: R/W; 1 = enabled.
  - BASE+2 STATUS: read-only; bit7 = busy (FSM not IDLE), bits[2:0] = active source id, bits[6:3] = 0.
  - BASE+3 SOFT_SET: write-1-to-set PENDING; reads 0.
- Bits at N_SRC and above read 0 and ignore writes.
- Edge capture:
  - Each SRC_RAISE is registered; prev=0 and current=1 sets PENDING[i].
  - A source holding RAISE high does not retrigger.
- Priority: lowest index wins among PENDING & MASK.
- FSM states:
  - IDLE: if (PENDING & MASK) != 0, latch the winner id, go to REQ.
  - REQ: CPU_INT_RAISE=1. On CPU_INT_ACK=1: clear PENDING[id], pulse SRC_ACK[id], go to GAP.
  - GAP: one cycle with CPU_INT_RAISE=0, then IDLE.
- Same-cycle set/clear conflicts: an edge set or SOFT_SET in the same cycle as a W1C clear or ack clear leaves the bit set. A new event is never lost.
- Clearing MASK or W1C-clearing the active PENDING bit while in REQ does not withdraw the request. The handshake completes and SRC_ACK[id] still pulses.
- CPU_INT_ACK in IDLE or GAP is ignored.

## Timing
- Reset values: PENDING=0, MASK=all ones (low N_SRC bits), FSM=IDLE, id=0, CPU_INT_RAISE=0, SRC_ACK=0, BUS_DATA high-Z, edge registers=0.
- A source held high across reset is therefore captured as an edge after reset.
- Bus write: takes effect at the edge where BUS_WE=1 and the address matches.
- Bus read:
  - Address match with BUS_WE=0 at edge k: data registered at k, BUS_DATA driven during cycle k+1.
  - Released when the next edge sees no read match.
- Request latency:
  - SRC_RAISE first sampled high at edge k: PENDING set after k.
  - CPU_INT_RAISE high after k+1 (2-cycle latency).
- Acknowledge:
  - CPU_INT_ACK sampled high at edge m: after m, CPU_INT_RAISE=0 and SRC_ACK[id]=1.
  - After m+1, SRC_ACK=0 and FSM is IDLE.
  - The next CPU_INT_RAISE is possible after m+2 at the earliest.
- Reset mid-handshake: all state is cleared at that edge. The CPU sees RAISE drop and SRC_ACK is not pulsed.

## Test plan
- Single source: after reset, raise SRC_RAISE[1] and hold it. Required:
  - CPU_INT_RAISE=1 two cycles later; STATUS reads 8'h81.
  - Ack: SRC_ACK=4'b0010 for exactly one cycle, then PENDING reads 0.
  - SRC_RAISE[1] still held high causes no re-raise.
- Priority: raise sources 3 and 0 in the same cycle. Required:
  - First service is id 0, with PENDING=8'h09 before ack.
  - After ack and the GAP cycle, the second service is id 3.
- Mask:
  - Write MASK=8'h0E, then raise source 0. Required: PENDING=8'h01 and CPU_INT_RAISE stays 0.
  - Write MASK=8'h0F. Required: CPU_INT_RAISE=1 after 1 cycle.
- Software and conflict:
  - Write SOFT_SET=8'h04. Required: source 2 is serviced.
  - Write PENDING=8'h04 (W1C) in the same cycle as a new SRC_RAISE[2] edge. Required: PENDING[2] remains 1.
- Reset mid-REQ: assert RESET=0 for one edge while CPU_INT_RAISE=1. Required:
  - CPU_INT_RAISE=0 and PENDING=0; SRC_ACK never pulses.
  - MASK reads 8'h0F; BUS_DATA is high-Z.
